// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB master bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_PROT_W = 3;

    // A single slave still needs a 1-bit index so the select vectors stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_slv_mux.sv
// Combinational return-path mux: picks prdata/pready/pslverr of the addressed slave.
module apb_slv_mux #(
    parameter int NUM_SLV  = 4,
    parameter int RD_WIDTH = 32,
    parameter int IDX_W    = 2
) (
    input  logic [IDX_W-1:0]            idx,
    input  logic [NUM_SLV*RD_WIDTH-1:0] prdata,
    input  logic [NUM_SLV-1:0]          pready,
    input  logic [NUM_SLV-1:0]          pslverr,
    output logic [RD_WIDTH-1:0]         sel_rdata,
    output logic                        sel_ready,
    output logic                        sel_err
);

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_rdata = prdata[i*RD_WIDTH +: RD_WIDTH];
                sel_ready = pready[i];
                sel_err   = pslverr[i];
            end
        end
    end

endmodule

// File: rtl/apb_mstr_bridge.sv
// APB3 master bridge: valid/ready command port to NUM_SLV APB slaves, with wait timeout
// and decode-error response. Define APB_BRIDGE_APB4_EN to add pstrb/pprot (APB4).
module apb_mstr_bridge
    import apb_pkg::*;
#(
    parameter int A_WIDTH     = 32,
    parameter int WD_WIDTH    = 32,
    parameter int RD_WIDTH    = 32,
    parameter int NUM_SLV     = 4,
    parameter int SLV_LSB     = 12,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                        pclk,
    input  logic                        preset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [A_WIDTH-1:0]          cmd_addr,
    input  logic [WD_WIDTH-1:0]         cmd_wdata,
    output logic                        rsp_valid,
    output logic [RD_WIDTH-1:0]         rsp_rdata,
    output logic                        rsp_err,
    output logic [A_WIDTH-1:0]          paddr,
    output logic                        pwrite,
    output logic [WD_WIDTH-1:0]         pwdata,
`ifdef APB_BRIDGE_APB4_EN
    input  logic [WD_WIDTH/8-1:0]       cmd_strb,
    input  logic [APB_PROT_W-1:0]       cmd_prot,
    output logic [WD_WIDTH/8-1:0]       pstrb,
    output logic [APB_PROT_W-1:0]       pprot,
`endif
    output logic [NUM_SLV-1:0]          psel,
    output logic                        penable,
    input  logic [NUM_SLV*RD_WIDTH-1:0] prdata,
    input  logic [NUM_SLV-1:0]          pready,
    input  logic [NUM_SLV-1:0]          pslverr
);

    localparam int IDX_W = idx_width(NUM_SLV);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    apb_state_e            state_q, state_d;
    logic [NUM_SLV-1:0]    psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [A_WIDTH-1:0]    paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [WD_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [RD_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifdef APB_BRIDGE_APB4_EN
    logic [WD_WIDTH/8-1:0] pstrb_q, pstrb_d;
    logic [APB_PROT_W-1:0] pprot_q, pprot_d;
`endif

    logic [IDX_W-1:0]    dec_idx;
    logic                dec_err;
    logic [RD_WIDTH-1:0] sel_rdata;
    logic                sel_ready;
    logic                sel_err;
    logic                timeout_hit;

    assign dec_idx     = (NUM_SLV > 1) ? cmd_addr[SLV_LSB +: IDX_W] : '0;
    assign dec_err     = ({1'b0, dec_idx} >= (IDX_W + 1)'(NUM_SLV));
    assign timeout_hit = (TIMEOUT_CYC > 0) && (cnt_q == TO_LAST);

    apb_slv_mux #(
        .NUM_SLV  (NUM_SLV),
        .RD_WIDTH (RD_WIDTH),
        .IDX_W    (IDX_W)
    ) u_slv_mux (
        .idx       (idx_q),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .sel_rdata (sel_rdata),
        .sel_ready (sel_ready),
        .sel_err   (sel_err)
    );

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
`ifdef APB_BRIDGE_APB4_EN
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    idx_d    = dec_idx;
`ifdef APB_BRIDGE_APB4_EN
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    pprot_d  = cmd_prot;
`endif
                    // Unmapped slave: answer with an error without touching the bus.
                    if (dec_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = SETUP;
                        psel_d  = NUM_SLV'(1) << dec_idx;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (sel_ready) begin
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_BRIDGE_APB4_EN
            pstrb_q     <= '0;
            pprot_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_BRIDGE_APB4_EN
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
`endif
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
`ifdef APB_BRIDGE_APB4_EN
    assign pstrb     = pstrb_q;
    assign pprot     = pprot_q;
`endif

endmodule

// File: tb/tb_apb_mstr_bridge.sv
// Self-checking bench for apb_mstr_bridge (3 slaves, 16-cycle timeout); responses
// are checked through an expectation queue filled when each command is issued.
module tb_apb_mstr_bridge;

    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            pclk;
    logic            preset_n;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [NS-1:0]   psel;
    logic            penable;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0]   pready;
    logic [NS-1:0]   pslverr;

    apb_mstr_bridge #(
        .A_WIDTH     (AW),
        .WD_WIDTH    (DW),
        .RD_WIDTH    (DW),
        .NUM_SLV     (NS),
        .SLV_LSB     (12),
        .TIMEOUT_CYC (16)
    ) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .psel      (psel),
        .penable   (penable),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic          write;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   slv_rdata;
        logic          slv_err;
        int            waits;
        logic [NS-1:0] exp_psel;
        logic          exp_err;
        logic [31:0]   exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    rsp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response scoreboard: every rsp_valid must match the oldest outstanding expectation.
    always @(negedge pclk) begin
        if (preset_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
                checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            end
        end
    end

    // Non-addressed slaves return ready/error/garbage to prove they are ignored.
    task automatic setSlaves(input int sel, input logic rdy, input logic err, input logic [31:0] data);
        for (int i = 0; i < NS; i++) begin
            pready[i]            = 1'b1;
            pslverr[i]           = 1'b1;
            prdata[i*DW +: DW]   = 32'hBAD0_BAD0;
        end
        if (sel >= 0) begin
            pready[sel]          = rdy;
            pslverr[sel]         = err;
            prdata[sel*DW +: DW] = data;
        end
    endtask

    // Called at a negedge; returns at the negedge where the response is visible.
    task automatic applyStimulus(input vec_t v);
        int   sel;
        rsp_t e;
        sel = -1;
        for (int i = 0; i < NS; i++)
            if (v.exp_psel[i]) sel = i;
        checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        e.err     = v.exp_err;
        e.rdata   = v.exp_rdata;
        exp_q.push_back(e);
        @(negedge pclk);
        cmd_valid = 1'b0;
        if (sel < 0) begin
            checkOutput("decerr_psel", 64'(psel), 64'd0);
            checkOutput("decerr_rsp_valid", 64'(rsp_valid), 64'd1);
            return;
        end
        checkOutput("setup_psel", 64'(psel), 64'(v.exp_psel));
        checkOutput("setup_penable", 64'(penable), 64'd0);
        checkOutput("setup_paddr", 64'(paddr), 64'(v.addr));
        checkOutput("setup_pwrite", 64'(pwrite), 64'(v.write));
        checkOutput("setup_pwdata", 64'(pwdata), 64'(v.wdata));
        setSlaves(sel, 1'b1, 1'b1, 32'hFFFF_FFFF);
        for (int k = 1; k <= v.waits + 1; k++) begin
            @(negedge pclk);
            checkOutput("access_psel", 64'(psel), 64'(v.exp_psel));
            checkOutput("access_penable", 64'(penable), 64'd1);
            checkOutput("access_paddr", 64'(paddr), 64'(v.addr));
            checkOutput("access_pwdata", 64'(pwdata), 64'(v.wdata));
            checkOutput("access_no_rsp", 64'(rsp_valid), 64'd0);
            if (k == v.waits + 1)
                setSlaves(sel, 1'b1, v.slv_err, v.slv_rdata);
            else
                setSlaves(sel, 1'b0, 1'b1, 32'hFFFF_FFFF);
        end
        @(negedge pclk);
        setSlaves(-1, 1'b0, 1'b0, 32'h0);
        pready  = '0;
        pslverr = '0;
        checkOutput("done_rsp_valid", 64'(rsp_valid), 64'd1);
        checkOutput("done_psel", 64'(psel), 64'd0);
        checkOutput("done_penable", 64'(penable), 64'd0);
        checkOutput("done_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        preset_n  = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        prdata    = '0;
        pready    = '0;
        pslverr   = '0;

        //         write  addr          wdata         slv_rdata     err  waits psel    exp_err exp_rdata
        vecs[0] = '{1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 0, 3'b100, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_1010, 32'h0,         32'h1234_5678, 1'b0, 3, 3'b010, 1'b0, 32'h1234_5678};
        vecs[2] = '{1'b0, 32'h0000_0008, 32'h0,         32'hCAFE_0000, 1'b1, 0, 3'b001, 1'b1, 32'hCAFE_0000};
        vecs[3] = '{1'b0, 32'h0000_3000, 32'h0,         32'h0,         1'b0, 0, 3'b000, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 32'h0001_1ABC, 32'h0BAD_F00D, 32'h7777_7777, 1'b1, 1, 3'b010, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_2FFC, 32'h0,         32'hA5A5_5A5A, 1'b0, 2, 3'b100, 1'b0, 32'hA5A5_5A5A};
        vecs[6] = '{1'b1, 32'hFFFF_F000, 32'h5555_AAAA, 32'h0,         1'b0, 0, 3'b000, 1'b1, 32'h0};
        vecs[7] = '{1'b0, 32'h0000_0100, 32'h0,         32'h0F0F_0F0F, 1'b0, 0, 3'b001, 1'b0, 32'h0F0F_0F0F};

        @(negedge pclk);
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
        checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        checkOutput("rst_psel", 64'(psel), 64'd0);
        checkOutput("rst_penable", 64'(penable), 64'd0);
        checkOutput("rst_pwrite", 64'(pwrite), 64'd0);
        checkOutput("rst_paddr", 64'(paddr), 64'd0);
        checkOutput("rst_pwdata", 64'(pwdata), 64'd0);
        #2 preset_n = 1'b1;
        @(negedge pclk);

        // Vectors run back-to-back: each new command is offered in the previous rsp cycle.
        for (int i = 0; i < 8; i++) begin
            $display("[TB] vector %0d addr=%08h write=%0d", i, vecs[i].addr, vecs[i].write);
            applyStimulus(vecs[i]);
        end
        @(negedge pclk);
        checkOutput("single_pulse", 64'(rsp_valid), 64'd0);

        // Timeout: slave 1 never answers.
        begin
            rsp_t e;
            int   cnt;
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = 32'h0000_1000;
            e.err     = 1'b1;
            e.rdata   = 32'h0;
            exp_q.push_back(e);
            @(negedge pclk);
            cmd_valid = 1'b0;
            checkOutput("to_setup_psel", 64'(psel), 64'b010);
            setSlaves(1, 1'b0, 1'b1, 32'hFFFF_FFFF);
            cnt = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge pclk);
                if (psel == 3'b000) break;
                cnt++;
            end
            checkOutput("to_access_cycles", 64'(cnt), 64'd16);
            checkOutput("to_rsp_valid", 64'(rsp_valid), 64'd1);
            checkOutput("to_penable", 64'(penable), 64'd0);
            pready  = '0;
            pslverr = '0;
            @(negedge pclk);
            checkOutput("to_single_pulse", 64'(rsp_valid), 64'd0);
        end

        // Reset during ACCESS: bus drops asynchronously and no response follows.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0000_0040;
        cmd_wdata = 32'h1357_9BDF;
        @(negedge pclk);
        cmd_valid = 1'b0;
        setSlaves(0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge pclk);
        checkOutput("pre_rst_penable", 64'(penable), 64'd1);
        #2 preset_n = 1'b0;
        #1;
        checkOutput("async_rst_psel", 64'(psel), 64'd0);
        checkOutput("async_rst_penable", 64'(penable), 64'd0);
        pready  = '0;
        pslverr = '0;
        @(negedge pclk);
        checkOutput("rst_no_rsp", 64'(rsp_valid), 64'd0);
        #2 preset_n = 1'b1;
        repeat (2) @(negedge pclk);
        checkOutput("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
        checkOutput("post_rst_ready", 64'(cmd_ready), 64'd1);

        // A zero-wait read after reset recovery.
        applyStimulus(vecs[7]);
        repeat (3) @(negedge pclk);
        checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
